// File: rtl/ysyx_23060203_csu.sv
// Control-flow supervisor: kills younger work on WB flush / EX redirect, drains bus traffic, then redirects fetch.
// Optional perf counters (wb/ex accepts, stall cycles) are built only when CSU_PERF_EN is defined.
module ysyx_23060203_csu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
`ifdef CSU_PERF_EN
    ,
    parameter int          CNT_W    = 32
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_flush,
    input  logic [31:0] wb_dnpc,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        ifu_idle,
    input  logic        lsu_idle,
    output logic        fe_flush,
    output logic        be_flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
`ifdef CSU_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_wb_cnt,
    output logic [CNT_W-1:0] perf_ex_cnt,
    output logic [CNT_W-1:0] perf_stl_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_REDIR = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_kind;
    logic [31:0] r_target;

    state_t      w_nxt_state;
    logic        w_nxt_kind;
    logic [31:0] w_nxt_target;
    logic        w_fe_flush;
    logic        w_be_flush;
    logic        w_redir_valid;
    logic [31:0] w_redir_pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_BOOT;
            r_kind   <= 1'b1;
            r_target <= RESET_PC;
        end else begin
            r_state  <= w_nxt_state;
            r_kind   <= w_nxt_kind;
            r_target <= w_nxt_target;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_kind    = r_kind;
        w_nxt_target  = r_target;
        w_fe_flush    = 1'b0;
        w_be_flush    = 1'b0;
        w_redir_valid = 1'b0;
        w_redir_pc    = r_target;
        case (r_state)
            S_BOOT: begin
                w_redir_valid = 1'b1;
                w_redir_pc    = RESET_PC;
                if (redir_ready) w_nxt_state = S_RUN;
            end
            S_RUN: begin
                w_fe_flush = wb_flush | ex_redirect;
                w_be_flush = wb_flush;
                // WB retires the older instruction, so it beats a same-cycle EX redirect
                if (wb_flush) begin
                    w_nxt_state  = S_DRAIN;
                    w_nxt_kind   = 1'b1;
                    w_nxt_target = wb_dnpc;
                end else if (ex_redirect) begin
                    w_nxt_state  = S_DRAIN;
                    w_nxt_kind   = 1'b0;
                    w_nxt_target = ex_target;
                end
            end
            S_DRAIN: begin
                w_fe_flush = 1'b1;
                w_be_flush = r_kind;
                if (wb_flush) begin
                    w_nxt_kind   = 1'b1;
                    w_nxt_target = wb_dnpc;
                end else if (ifu_idle && (lsu_idle || !r_kind)) begin
                    w_nxt_state = S_REDIR;
                end
            end
            S_REDIR: begin
                w_redir_valid = 1'b1;
                w_fe_flush    = 1'b1;
                w_be_flush    = r_kind;
                // A WB flush withdraws the offer even if IFU accepted it this cycle
                if (wb_flush) begin
                    w_nxt_state  = S_DRAIN;
                    w_nxt_kind   = 1'b1;
                    w_nxt_target = wb_dnpc;
                end else if (redir_ready) begin
                    w_nxt_state = S_RUN;
                end
            end
            default: w_nxt_state = S_BOOT;
        endcase
    end

    assign fe_flush    = w_fe_flush;
    assign be_flush    = w_be_flush;
    assign redir_valid = w_redir_valid;
    assign redir_pc    = w_redir_pc;

`ifdef CSU_PERF_EN
    logic             w_wb_acc;
    logic             w_ex_acc;
    logic             w_stall;
    logic [CNT_W-1:0] r_wb_cnt;
    logic [CNT_W-1:0] r_ex_cnt;
    logic [CNT_W-1:0] r_stl_cnt;

    assign w_wb_acc = (r_state != S_BOOT) && wb_flush;
    assign w_ex_acc = (r_state == S_RUN) && ex_redirect && !wb_flush;
    assign w_stall  = (r_state == S_DRAIN) || (r_state == S_REDIR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wb_cnt  <= '0;
            r_ex_cnt  <= '0;
            r_stl_cnt <= '0;
        end else begin
            if (w_wb_acc && (r_wb_cnt != '1))  r_wb_cnt  <= r_wb_cnt + CNT_W'(1);
            if (w_ex_acc && (r_ex_cnt != '1))  r_ex_cnt  <= r_ex_cnt + CNT_W'(1);
            if (w_stall && (r_stl_cnt != '1))  r_stl_cnt <= r_stl_cnt + CNT_W'(1);
        end
    end

    assign perf_wb_cnt  = r_wb_cnt;
    assign perf_ex_cnt  = r_ex_cnt;
    assign perf_stl_cnt = r_stl_cnt;
`endif

endmodule
